modport_counter: RTL and testbench
==================================

# modport_counter

Synchronous 4-bit modulo-12 up/down counter with parallel load, used as the DUT of the counter verification environment. It counts through 0..11 in either direction, wrapping at both ends. It can be preset from a 4-bit data input, and its registered count is observed by the monitor side of the environment.

## Interface
- No parameters. Modulus is fixed at 12 and width at 4 bits.
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Reset, synchronous and active-high; sampled on the rising edge of clk.
- load  input  1  Synchronous parallel load enable.
- up_down  input  1  Direction select: 1 counts up, 0 counts down.
- Din  input  4  Parallel load value.
- count  output  4  Current counter value, driven directly from a register.

## Operation
- State is one 4-bit register, `count`. Legal values are 0..11.
- At each rising edge of clk, exactly one action applies, chosen by the first matching rule in priority order:
  - rst=1: count <= 0. Load and direction are ignored.
  - load=1: if Din <= 11, count <= Din. If Din is 12..15 (out of range), count <= 0. up_down is ignored.
  - up_down=1: if count == 11, count <= 0 (wrap); otherwise count <= count + 1.
  - up_down=0: if count == 0, count <= 11 (wrap); otherwise count <= count - 1.
- There is no hold/enable input. When neither rst nor load is asserted, the counter advances every cycle.
- If count ever holds an illegal value (12..15), the next non-reset, non-load edge forces count <= 0 in either direction.
- No combinational path exists from any input to count.

## Timing
- Reset value: count = 0. Reset takes effect only at a clock edge; asserting rst between edges has no effect until the next edge.
- Latency:
  - Load: one cycle. Din is sampled at edge N and visible on count after edge N.
  - Count step: one cycle per edge.
- Reset asserted mid-sequence (during load or counting) zeroes count at that edge. Counting resumes from 0 on the first edge at which rst=0.
- Inputs must meet setup/hold around the rising edge. The environment drives inputs 1 ns after the edge and samples count 1 ns before the edge, so count must be stable within the cycle after the edge.
- Simultaneous events:
  - rst with load: reset wins.
  - load with up_down: load wins.
  - A direction change takes effect on the same edge at which it is sampled.

## Test plan
- Reset: hold rst=1 for 2 edges with arbitrary load/Din/up_down -> count = 0 after the first edge and stays 0.
- Up-count wrap: after reset, up_down=1, load=0 for 13 edges -> count sequence 1,2,...,11,0,1.
- Down-count wrap: after reset, up_down=0 for 3 edges -> count 11,10,9.
- Load in range: load=1, Din=7 for one edge, then up_down=1 for 5 edges -> count 7, then 8,9,10,11,0.
- Load out of range and priority:
  - load=1, Din=13 -> count = 0.
  - rst=1 with load=1, Din=5 -> count = 0.
  - load=1, Din=11 with up_down=0 -> count = 11, and the next down edge gives 10.
- Mid-run reset and direction flip: count up to 6, assert rst for one edge -> 0. Then up_down=0 -> 11. Then up_down=1 -> 0.

Source files
------------

// File: rtl/modport_counter.sv
// Modulo-12 up/down counter with synchronous parallel load.
// Out-of-range load data and any illegal held value collapse to zero.
module modport_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       up_down,
  input  logic [3:0] Din,
  output logic [3:0] count
);

  localparam logic [3:0] CNT_MAX = 4'd11;

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (Din <= CNT_MAX) ? Din : 4'd0;
    end else if (count_q > CNT_MAX) begin
      // An illegal state recovers to zero whatever the direction.
      count_d = 4'd0;
    end else if (up_down) begin
      count_d = (count_q == CNT_MAX) ? 4'd0 : count_q + 4'd1;
    end else begin
      count_d = (count_q == 4'd0) ? CNT_MAX : count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_modport_counter.sv
// Bench for modport_counter: a vector table plus a mid-cycle reset glitch,
// with expected counts queued on drive and compared after the edge.
module tb_modport_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic       up_down;
  logic [3:0] Din;
  logic [3:0] count;

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic       up_down;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         n_pass;
  int         n_total;
  logic [3:0] last_exp;
  bit         last_valid;

  modport_counter dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .up_down (up_down),
    .Din     (Din),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic add(input string name, input logic r, input logic l, input logic u,
                     input logic [3:0] d, input logic [3:0] e);
    vec_t v;
    v.name = name; v.rst = r; v.load = l; v.up_down = u; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // Called 1 ns after an edge: drive, confirm count holds until just before
  // the next edge, then compare the queued expectation after that edge.
  task automatic apply(input vec_t v, input bit glitch_rst);
    logic [3:0] e;
    rst = v.rst; load = v.load; up_down = v.up_down; Din = v.din;
    sb.push_back(v.exp);
    if (glitch_rst) begin
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      #3;
    end else begin
      #7;
    end
    if (last_valid) check({v.name, "_hold"}, count, last_exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(v.name, count, e);
    last_exp = e;
    last_valid = 1'b1;
  endtask

  initial begin
    vec_t g;
    n_pass = 0; n_total = 0; last_valid = 1'b0; last_exp = 4'd0;
    rst = 1'b1; load = 1'b0; up_down = 1'b0; Din = 4'd0;

    add("rst_with_load", 1, 1, 1, 4'd9, 4'd0);
    add("rst_hold",      1, 0, 0, 4'd3, 4'd0);
    for (int i = 1; i <= 13; i++) begin
      logic [3:0] e;
      e = 4'(i % 12);
      add("up_wrap", 0, 0, 1, 4'd0, e);
    end
    add("rst_before_down", 1, 0, 1, 4'd0, 4'd0);
    add("down_wrap", 0, 0, 0, 4'd0, 4'd11);
    add("down_10",   0, 0, 0, 4'd0, 4'd10);
    add("down_9",    0, 0, 0, 4'd0, 4'd9);
    add("load_7",    0, 1, 1, 4'd7, 4'd7);
    add("up_after_load", 0, 0, 1, 4'd0, 4'd8);
    add("up_after_load", 0, 0, 1, 4'd0, 4'd9);
    add("up_after_load", 0, 0, 1, 4'd0, 4'd10);
    add("up_after_load", 0, 0, 1, 4'd0, 4'd11);
    add("up_after_load", 0, 0, 1, 4'd0, 4'd0);
    add("load_13_oor",   0, 1, 1, 4'd13, 4'd0);
    add("load_3",        0, 1, 0, 4'd3, 4'd3);
    add("rst_beats_load", 1, 1, 0, 4'd5, 4'd0);
    add("load_11_down",  0, 1, 0, 4'd11, 4'd11);
    add("down_after_11", 0, 0, 0, 4'd0, 4'd10);
    add("rst_mid",       1, 0, 1, 4'd0, 4'd0);
    for (int i = 1; i <= 6; i++) begin
      logic [3:0] e;
      e = 4'(i);
      add("up_to_6", 0, 0, 1, 4'd0, e);
    end
    add("rst_at_6",      1, 0, 1, 4'd0, 4'd0);
    add("flip_down",     0, 0, 0, 4'd0, 4'd11);
    add("flip_up",       0, 0, 1, 4'd0, 4'd0);
    add("load_12_oor",   0, 1, 0, 4'd12, 4'd0);
    add("load_5",        0, 1, 0, 4'd5, 4'd5);
    add("load_15_oor",   0, 1, 1, 4'd15, 4'd0);
    add("load_0",        0, 1, 1, 4'd0, 4'd0);
    add("down_from_0",   0, 0, 0, 4'd0, 4'd11);
    add("load_4",        0, 1, 0, 4'd4, 4'd4);

    // Align to 1 ns after an edge before the first vector is driven.
    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], 1'b0);

    // A reset pulse that falls before the edge must not affect the count.
    g.name = "rst_glitch_ignored"; g.rst = 1'b0; g.load = 1'b0; g.up_down = 1'b1;
    g.din = 4'd0; g.exp = 4'd5;
    apply(g, 1'b1);
    g.name = "after_glitch"; g.exp = 4'd6;
    apply(g, 1'b0);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
